// File: rtl/am_insertion_pkg.sv
// Shared constants for the multi-lane alignment-marker inserter: marker tables and BIP parity.
// Latency: none (package only).
// Backpressure: none (package only).
package am_insertion_pkg;

    localparam int BLK_W = 66;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    // Marker halves per lane: LOW = M0,M1,M2 ; HIGH = M4,M5,M6 (bitwise complement of LOW).
    localparam logic [23:0] AM_TABLE_100G_LOW [20] = '{
        24'hC1_68_21, 24'h9D_71_8E, 24'h59_4B_E8, 24'h4D_95_7B, 24'hF5_07_09,
        24'hDD_14_C2, 24'h9A_4A_26, 24'h7B_45_66, 24'hA0_24_76, 24'h68_C9_FB,
        24'hFD_6C_99, 24'hB9_91_55, 24'h5C_B9_B2, 24'h1A_F8_BD, 24'h83_C7_CA,
        24'h35_36_CD, 24'hC4_31_4C, 24'hAD_D6_B7, 24'h5F_66_2A, 24'hC0_F0_E5
    };
    localparam logic [23:0] AM_TABLE_100G_HIGH [20] = '{
        24'h3E_97_DE, 24'h62_8E_71, 24'hA6_B4_17, 24'hB2_6A_84, 24'h0A_F8_F6,
        24'h22_EB_3D, 24'h65_B5_D9, 24'h84_BA_99, 24'h5F_DB_89, 24'h97_36_04,
        24'h02_93_66, 24'h46_6E_AA, 24'hA3_46_4D, 24'hE5_07_42, 24'h7C_38_35,
        24'hCA_C9_32, 24'h3B_CE_B3, 24'h52_29_48, 24'hA0_99_D5, 24'h3F_0F_1A
    };
    localparam logic [23:0] AM_TABLE_40G_LOW [4] = '{
        24'h90_76_47, 24'hF0_C4_E6, 24'hC5_65_9B, 24'hA2_79_3D
    };
    localparam logic [23:0] AM_TABLE_40G_HIGH [4] = '{
        24'h6F_89_B8, 24'h0F_3B_19, 24'h3A_9A_64, 24'h5D_86_C2
    };

    // Column parity of the 8 payload bytes; the two sync bits fold into bits 3 and 4.
    function automatic logic [7:0] bip_parity(input logic [BLK_W-1:0] blk);
        logic [7:0] p;
        p = '0;
        for (int k = 0; k < 8; k++) begin
            p = p ^ blk[8*k +: 8];
        end
        p[3] = p[3] ^ blk[65];
        p[4] = p[4] ^ blk[64];
        return p;
    endfunction

endpackage

// File: rtl/am_lane_insert.sv
// One lane: BIP accumulator, data/marker select and output register.
// Latency: 1 cycle data_i -> data_o.
// Backpressure: none locally; the top stalls upstream during marker slots.
module am_lane_insert
    import am_insertion_pkg::*;
#(
    parameter int LANE    = 0,
    parameter int N_LANES = 20
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             valid_i,
    input  logic             enable_i,
    input  logic             am_slot_i,
    input  logic             bip_err_i,
    input  logic [BLK_W-1:0] data_i,
    output logic [BLK_W-1:0] data_o
);

    localparam logic [23:0] AM_LO = (N_LANES == 4) ? AM_TABLE_40G_LOW[LANE % 4]
                                                   : AM_TABLE_100G_LOW[LANE % 20];
    localparam logic [23:0] AM_HI = (N_LANES == 4) ? AM_TABLE_40G_HIGH[LANE % 4]
                                                   : AM_TABLE_100G_HIGH[LANE % 20];

    logic [7:0]       acc_q, acc_d;
    logic [BLK_W-1:0] data_q, data_d;
    logic [7:0]       bip3;
    logic [BLK_W-1:0] am_blk;

    // Marker as emitted; BIP7 always reflects the true BIP3, even when BIP3 is corrupted.
    always_comb begin
        bip3   = acc_q ^ {7'b0, bip_err_i};
        am_blk = {SYNC_CTRL, AM_LO, bip3, AM_HI, ~acc_q};
    end

    // Slot update: marker restarts the span, data folds in, bypass passes through with acc frozen.
    always_comb begin
        acc_d  = acc_q;
        data_d = data_q;
        if (valid_i) begin
            if (am_slot_i) begin
                data_d = am_blk;
                acc_d  = bip_parity(am_blk);
            end else begin
                data_d = data_i;
                if (enable_i) begin
                    acc_d = acc_q ^ bip_parity(data_i);
                end
            end
        end
    end

    // Accumulator and output register.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            acc_q  <= '0;
            data_q <= '0;
        end else begin
            acc_q  <= acc_d;
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/am_insertion_multilane.sv
// Multi-lane AM inserter: period counter, upstream stall, per-lane insert. Optional AM_INSERT_BIP_ERR_INJ_EN adds i_bip_err_lane.
// Latency: 1 cycle i_data -> o_data; o_valid/o_am_flag aligned with o_data.
// Backpressure: o_ready drops combinationally in AM slots (and in reset); upstream holds its block.
module am_insertion_multilane
    import am_insertion_pkg::*;
#(
    parameter int LEN_CODED_BLOCK = 66,
    parameter int N_LANES         = 20,
    parameter int AM_PERIOD       = 16384,
    parameter int NB_BIP          = 8,
    parameter int NB_AM_ENCODING  = 24
) (
    input  logic                               i_clock,
    input  logic                               i_reset,
    input  logic                               i_valid,
    input  logic                               i_enable,
`ifdef AM_INSERT_BIP_ERR_INJ_EN
    input  logic [N_LANES-1:0]                 i_bip_err_lane,
`endif
    input  logic [LEN_CODED_BLOCK*N_LANES-1:0] i_data,
    output logic                               o_ready,
    output logic                               o_valid,
    output logic                               o_am_flag,
    output logic [LEN_CODED_BLOCK*N_LANES-1:0] o_data
);

    localparam int W     = LEN_CODED_BLOCK * N_LANES;
    localparam int CNT_W = $clog2(AM_PERIOD);

    if (!(N_LANES == 4 || N_LANES == 20)) begin : g_bad_lanes
        $error("am_insertion_multilane: N_LANES must be 4 or 20");
    end
    if (AM_PERIOD < 2) begin : g_bad_period
        $error("am_insertion_multilane: AM_PERIOD must be at least 2");
    end
    if (LEN_CODED_BLOCK != BLK_W || NB_BIP != 8 || NB_AM_ENCODING != 24) begin : g_bad_fmt
        $error("am_insertion_multilane: block/BIP/marker widths are fixed at 66/8/24");
    end

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, am_flag_q;
    logic               am_slot;
    logic [N_LANES-1:0] bip_err;

`ifdef AM_INSERT_BIP_ERR_INJ_EN
    assign bip_err = i_bip_err_lane;
`else
    assign bip_err = '0;
`endif

    assign am_slot = i_valid && i_enable && (cnt_q == '0);
    assign o_ready = !i_reset && !am_slot;

    // Slot counter advances on enabled valid slots only, wrapping at the period end.
    always_comb begin
        cnt_d = cnt_q;
        if (i_valid && i_enable) begin
            cnt_d = (cnt_q == CNT_W'(AM_PERIOD - 1)) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Counter and output strobes.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            am_flag_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            valid_q   <= i_valid;
            am_flag_q <= am_slot;
        end
    end

    assign o_valid   = valid_q;
    assign o_am_flag = am_flag_q;

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        am_lane_insert #(
            .LANE    (g),
            .N_LANES (N_LANES)
        ) u_lane (
            .clock_i   (i_clock),
            .reset_i   (i_reset),
            .valid_i   (i_valid),
            .enable_i  (i_enable),
            .am_slot_i (am_slot),
            .bip_err_i (bip_err[g]),
            .data_i    (i_data[W-1-g*LEN_CODED_BLOCK -: LEN_CODED_BLOCK]),
            .data_o    (o_data[W-1-g*LEN_CODED_BLOCK -: LEN_CODED_BLOCK])
        );
    end

endmodule

// File: tb/tb_am_insertion_multilane.sv
// Scoreboard bench for am_insertion_multilane: 20-lane and 4-lane instances, AM_PERIOD=4.
// Latency: expected entries are pushed at drive time and popped one cycle later.
// Backpressure: the upstream model holds its block whenever o_ready is low.
module tb_am_insertion_multilane;

    localparam int NL     = 20;
    localparam int W      = 66 * NL;
    localparam int W4     = 66 * 4;
    localparam int PERIOD = 4;
`ifdef AM_INSERT_BIP_ERR_INJ_EN
    localparam bit INJ = 1'b1;
`else
    localparam bit INJ = 1'b0;
`endif

    localparam logic [23:0] TB_LO [20] = '{
        24'hC16821, 24'h9D718E, 24'h594BE8, 24'h4D957B, 24'hF50709, 24'hDD14C2, 24'h9A4A26,
        24'h7B4566, 24'hA02476, 24'h68C9FB, 24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD,
        24'h83C7CA, 24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5
    };

    localparam logic [65:0] H_00   = {2'b10, 64'hC16821_00_3E97DE_FF};
    localparam logic [65:0] H_FF   = {2'b10, 64'hC16821_FF_3E97DE_00};
    localparam logic [65:0] H_FE   = {2'b10, 64'hC16821_FE_3E97DE_00};
    localparam logic [65:0] H_FE01 = {2'b10, 64'hC16821_FE_3E97DE_01};
    localparam logic [65:0] H4_FIRST = {2'b10, 64'hA2793D_00_5D86C2_FF};
    localparam logic [65:0] H4_LATER = {2'b10, 64'hA2793D_08_5D86C2_F7};

    logic          clk, rst, v, en;
    logic [W-1:0]  din, od;
    logic [W4-1:0] din4, od4;
    logic          rdy, ov, oam, rdy4, ov4, oam4;
    logic [NL-1:0] err_drv;

    am_insertion_multilane #(.N_LANES(20), .AM_PERIOD(PERIOD)) dut20 (
        .i_clock(clk), .i_reset(rst), .i_valid(v), .i_enable(en),
`ifdef AM_INSERT_BIP_ERR_INJ_EN
        .i_bip_err_lane(err_drv),
`endif
        .i_data(din), .o_ready(rdy), .o_valid(ov), .o_am_flag(oam), .o_data(od)
    );

    am_insertion_multilane #(.N_LANES(4), .AM_PERIOD(PERIOD)) dut4 (
        .i_clock(clk), .i_reset(rst), .i_valid(v), .i_enable(en),
`ifdef AM_INSERT_BIP_ERR_INJ_EN
        .i_bip_err_lane(4'b0),
`endif
        .i_data(din4), .o_ready(rdy4), .o_valid(ov4), .o_am_flag(oam4), .o_data(od4)
    );

    typedef struct {
        logic         vld;
        logic         am;
        logic [W-1:0] data;
        logic         chk0;
        logic [65:0]  hand0;
        logic [65:0]  h4;
    } exp_t;

    exp_t         q[$];
    exp_t         cur;
    logic [W-1:0] src[$];
    int           mcnt;
    logic [7:0]   macc[NL];
    bit           first4;
    int           n_chk = 0;
    int           n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [65:0] lane(input logic [W-1:0] bus, input int l);
        return bus[W-1-l*66 -: 66];
    endfunction

    function automatic logic [7:0] bip(input logic [65:0] b);
        logic [7:0] p;
        p = '0;
        for (int j = 0; j < 64; j++) p[j%8] = p[j%8] ^ b[j];
        p[3] = p[3] ^ b[65];
        p[4] = p[4] ^ b[64];
        return p;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic chk66(input string nm, input logic [65:0] act, input logic [65:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic chk_bus(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
        int bad;
        bad = 0;
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            for (int l = NL - 1; l >= 0; l--) if (lane(act, l) !== lane(expv, l)) bad = l;
            $display("FAIL %s lane %0d: got %h expected %h at %0t", nm, bad,
                     lane(act, bad), lane(expv, bad), $time);
        end
    endtask

    // Drive one cycle, advance the reference model and queue the expected output.
    task automatic step(input bit vv, input bit ee, input logic [NL-1:0] er,
                        input bit c0, input logic [65:0] h0);
        exp_t          e;
        logic [NL-1:0] er_eff;
        logic [65:0]   blk;
        logic [7:0]    b3;
        bit            slot;
        @(negedge clk);
        v       = vv;
        en      = ee;
        err_drv = er;
        din     = (src.size() > 0) ? src[0] : '0;
        slot    = vv && ee && (mcnt == 0);
        er_eff  = er & {NL{INJ}};
        e.vld = vv; e.am = slot; e.data = '0; e.chk0 = c0; e.hand0 = h0; e.h4 = '0;
        if (vv) begin
            if (slot) begin
                for (int l = 0; l < NL; l++) begin
                    b3  = macc[l] ^ {7'b0, er_eff[l]};
                    blk = {2'b10, TB_LO[l], b3, ~TB_LO[l], ~macc[l]};
                    e.data[W-1-l*66 -: 66] = blk;
                    macc[l] = bip(blk);
                end
                e.h4   = first4 ? H4_FIRST : H4_LATER;
                first4 = 1'b0;
            end else begin
                e.data = din;
                if (ee) for (int l = 0; l < NL; l++) macc[l] = macc[l] ^ bip(lane(din, l));
                if (src.size() > 0) void'(src.pop_front());
            end
            if (ee) mcnt = (mcnt + 1) % PERIOD;
        end
        q.push_back(e);
        #1;
        chk1("o_ready", rdy, !slot);
        chk1("o_ready_4lane", rdy4, !slot);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; v = 1'b1; en = 1'b1;
        #1;
        chk1("o_ready_in_reset", rdy, 1'b0);
        @(negedge clk);
        chk1("reset_o_valid", ov, 1'b0);
        chk1("reset_o_am_flag", oam, 1'b0);
        chk_bus("reset_o_data", od, '0);
        rst = 1'b0; v = 1'b0;
        mcnt = 0; first4 = 1'b1;
        for (int l = 0; l < NL; l++) macc[l] = '0;
        src.delete();
    endtask

    task automatic fill_const(input int n, input logic [65:0] blk);
        for (int k = 0; k < n; k++) src.push_back({NL{blk}});
    endtask

    // Monitor: compare every registered output against the queued expectation.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            cur = q.pop_front();
            chk1("o_valid", ov, cur.vld);
            chk1("o_valid_4lane", ov4, cur.vld);
            if (cur.vld) begin
                chk1("o_am_flag", oam, cur.am);
                chk1("o_am_flag_4lane", oam4, cur.am);
                chk_bus("o_data", od, cur.data);
                if (cur.am && cur.chk0) chk66("am_lane0_hand", lane(od, 0), cur.hand0);
                if (cur.am) begin
                    chk66("am_lane3_40g", od4[65:0], cur.h4);
                end else begin
                    n_chk++;
                    if (od4 !== '0) begin
                        n_fail++;
                        $display("FAIL o_data_4lane: got %h expected 0", od4);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int vp[20] = '{1, 0, 0, 1, 0, 1, 1, 0, 0, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};
    int ep[14] = '{1, 1, 1, 0, 0, 1, 1, 0, 1, 1, 1, 1, 0, 1};
    logic [W-1:0] blkbus;

    initial begin
        rst = 1'b1; v = 1'b0; en = 1'b0; din = '0; din4 = '0; err_drv = '0;
        mcnt = 0; first4 = 1'b1;
        for (int l = 0; l < NL; l++) macc[l] = '0;

        // All-zero payload: both markers carry BIP3=00, four slots apart.
        do_reset();
        fill_const(6, {2'b10, 64'h0});
        step(1, 1, '0, 1, H_00);
        repeat (3) step(1, 1, '0, 0, '0);
        step(1, 1, '0, 1, H_00);
        repeat (3) step(1, 1, '0, 0, '0);

        // Payload 0xFF: BIP3=FF; optional corruption of lane 0 and its effect on the next span.
        do_reset();
        fill_const(9, {2'b10, 64'h00000000_000000FF});
        step(1, 1, '0, 1, H_00);
        repeat (3) step(1, 1, '0, 0, '0);
        step(1, 1, NL'(1), 1, INJ ? H_FE : H_FF);
        repeat (3) step(1, 1, '0, 0, '0);
        step(1, 1, '0, 1, INJ ? H_FE01 : H_FF);

        // Valid gaps with distinct blocks; markers counted in valid slots only.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            for (int l = 0; l < NL; l++)
                blkbus[W-1-l*66 -: 66] = {2'b01, (32'(k) * 32'h01010101) ^ 32'(l), 32'h5A5A0000 + 32'(k*16 + l)};
            src.push_back(blkbus);
        end
        for (int i = 0; i < 20; i++) step(vp[i] != 0, 1, '0, 0, '0);

        // Bypass windows mid-period, including a disabled slot where a marker was due.
        for (int k = 0; k < 14; k++) begin
            for (int l = 0; l < NL; l++)
                blkbus[W-1-l*66 -: 66] = {2'b11, 32'hC0DE0000 + 32'(k), 32'(l) << 8};
            src.push_back(blkbus);
        end
        for (int i = 0; i < 14; i++) step(1, ep[i] != 0, '0, 0, '0);
        step(0, 0, '0, 0, '0);

        // Mid-period reset discards the partial span.
        do_reset();
        fill_const(2, {2'b10, 64'h1234_5678_9ABC_DEF0});
        step(1, 1, '0, 1, H_00);
        repeat (2) step(1, 1, '0, 0, '0);
        repeat (2) step(0, 1, '0, 0, '0);

        @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
